mic_peak_meter: RTL and testbench



---
 rtl/mic_peak_meter_pkg.sv | 11 +
 rtl/mic_peak_meter_level_to_bar.sv | 17 +
 rtl/mic_peak_meter.sv | 87 ++++++++
 tb/tb_mic_peak_meter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mic_peak_meter_pkg.sv
// Shared constants for the microphone level path; the display consumers
// import the same values so their scaling matches the meter.
package mic_peak_meter_pkg;
  localparam int SAMPLE_W    = 12;
  localparam int AMP_W       = 11;
  localparam int LEVEL_SHIFT = 7;
  localparam int LEVEL_W     = 4;
  localparam int BAR_W       = 16;

  localparam logic [SAMPLE_W-1:0] ADC_MIDPOINT = 12'd2048;
endpackage

// File: rtl/mic_peak_meter_level_to_bar.sv
// Combinational thermometer decoder: bits [lvl:0] set, so level 0 still
// lights the lowest LED.
module level_to_bar
  import mic_peak_meter_pkg::*;
(
  input  logic [LEVEL_W-1:0] lvl,
  output logic [BAR_W-1:0]   bar
);

  always_comb begin
    bar = '0;
    for (int i = 0; i < BAR_W; i++) begin
      bar[i] = (LEVEL_W'(i) <= lvl);
    end
  end

endmodule

// File: rtl/mic_peak_meter.sv
// Windowed peak detector: tracks the largest sample per WINDOW strobes and
// converts it to a 4-bit volume level with optional peak-hold decay.
module mic_peak_meter
  import mic_peak_meter_pkg::*;
#(
  parameter int unsigned WINDOW = 4000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                decay_en,
  input  logic                freeze,
  output logic [LEVEL_W-1:0]  level,
  output logic [BAR_W-1:0]    bar,
  output logic                level_valid
);

  localparam int CNT_W = $clog2(WINDOW);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);

  function automatic logic [LEVEL_W-1:0] peak_to_level(input logic [SAMPLE_W-1:0] pk);
    logic [AMP_W-1:0] amp;
    amp = (pk > ADC_MIDPOINT) ? AMP_W'(pk - ADC_MIDPOINT) : '0;
    return LEVEL_W'(amp >> LEVEL_SHIFT);
  endfunction

  logic [CNT_W-1:0]    cnt_p0;
  logic [SAMPLE_W-1:0] run_max_p0;
  logic [SAMPLE_W-1:0] win_peak;
  logic [LEVEL_W-1:0]  new_lvl;
  logic [LEVEL_W-1:0]  level_nxt;
  logic [BAR_W-1:0]    bar_nxt;
  logic                win_end;
  logic                upd;

  // Stage p0: accumulation; the window-ending sample is folded into the peak.
  always_comb begin
    win_peak  = (sample > run_max_p0) ? sample : run_max_p0;
    new_lvl   = peak_to_level(win_peak);
    win_end   = sample_valid && (cnt_p0 == CNT_LAST);
    upd       = win_end && !freeze;
    level_nxt = level;
    if (upd) begin
      if (!decay_en || (new_lvl >= level)) begin
        level_nxt = new_lvl;
      end else begin
        level_nxt = level - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_p0     <= '0;
      run_max_p0 <= '0;
    end else if (sample_valid) begin
      if (win_end) begin
        cnt_p0     <= '0;
        run_max_p0 <= '0;
      end else begin
        cnt_p0     <= cnt_p0 + 1'b1;
        run_max_p0 <= win_peak;
      end
    end
  end

  // Decoding the next-state level keeps bar in step with level.
  level_to_bar u_level_to_bar (
    .lvl (level_nxt),
    .bar (bar_nxt)
  );

  // Stage p1: registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level       <= '0;
      bar         <= BAR_W'(1);
      level_valid <= 1'b0;
    end else begin
      level       <= level_nxt;
      bar         <= bar_nxt;
      level_valid <= upd;
    end
  end

endmodule

// File: tb/tb_mic_peak_meter.sv
// Directed bench for mic_peak_meter: one instance with a 4-sample window and
// one with a 2-sample window driven by back-to-back strobes.
module tb_mic_peak_meter;
  import mic_peak_meter_pkg::*;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                sample_valid = 1'b0;
  logic [SAMPLE_W-1:0] sample = '0;
  logic                decay_en = 1'b0;
  logic                freeze = 1'b0;
  logic [LEVEL_W-1:0]  level;
  logic [BAR_W-1:0]    bar;
  logic                level_valid;

  logic                sample_valid2 = 1'b0;
  logic [SAMPLE_W-1:0] sample2 = '0;
  logic [LEVEL_W-1:0]  level2;
  logic [BAR_W-1:0]    bar2;
  logic                level_valid2;

  int errors = 0;
  int checks = 0;
  int lv_cnt = 0;
  int lv_snap;

  mic_peak_meter #(.WINDOW(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_valid (sample_valid),
    .sample       (sample),
    .decay_en     (decay_en),
    .freeze       (freeze),
    .level        (level),
    .bar          (bar),
    .level_valid  (level_valid)
  );

  mic_peak_meter #(.WINDOW(2)) dut2 (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_valid (sample_valid2),
    .sample       (sample2),
    .decay_en     (1'b0),
    .freeze       (1'b0),
    .level        (level2),
    .bar          (bar2),
    .level_valid  (level_valid2)
  );

  always #5 clk = ~clk;

  // Count level_valid cycles shortly after each rising edge.
  always begin
    @(posedge clk);
    #2;
    if (level_valid) lv_cnt++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic strobe(input logic [SAMPLE_W-1:0] s);
    @(negedge clk);
    sample       = s;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic window4(input logic [SAMPLE_W-1:0] s0, s1, s2, s3);
    strobe(s0);
    strobe(s1);
    strobe(s2);
    strobe(s3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [SAMPLE_W-1:0] v2[6];
    int exp2[3];

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("reset_level", level, 0);
    chk("reset_bar", bar, 16'h0001);
    chk("reset_valid", level_valid, 0);

    // Static tone, raw mode.
    window4(12'd2048, 12'd2300, 12'd3000, 12'd2100);
    chk("tone_level", level, 7);
    chk("tone_bar", bar, 16'h00FF);
    chk("tone_valid_hi", level_valid, 1);
    @(negedge clk);
    chk("tone_valid_lo", level_valid, 0);

    // Final sample of the window must count.
    window4(12'd2048, 12'd2048, 12'd2048, 12'd4095);
    chk("final_level", level, 15);
    chk("final_bar", bar, 16'hFFFF);

    // Reset mid-window discards the partial window.
    strobe(12'd4095);
    strobe(12'd4095);
    reset_n = 1'b0;
    #1;
    chk("midrst_level", level, 0);
    chk("midrst_bar", bar, 16'h0001);
    chk("midrst_valid", level_valid, 0);
    @(negedge clk);
    reset_n = 1'b1;
    lv_snap = lv_cnt;
    strobe(12'd2048);
    strobe(12'd2048);
    strobe(12'd2048);
    chk("midrst_no_early_valid", lv_cnt - lv_snap, 0);
    strobe(12'd2048);
    chk("midrst_window_pulse", lv_cnt - lv_snap, 1);
    chk("midrst_peak_cleared", level, 0);

    // Peak hold with one-step decay.
    decay_en = 1'b1;
    window4(12'd2048, 12'd3584, 12'd2048, 12'd2048);
    chk("decay_attack12", level, 12);
    window4(12'd2048, 12'd2048, 12'd2048, 12'd2048);
    chk("decay_11", level, 11);
    chk("decay_11_valid", level_valid, 1);
    window4(12'd2048, 12'd2048, 12'd2048, 12'd2048);
    chk("decay_10", level, 10);
    window4(12'd2048, 12'd2048, 12'd2048, 12'd2048);
    chk("decay_9", level, 9);
    chk("decay_9_bar", bar, 16'h03FF);
    window4(12'd2048, 12'd2048, 12'd3840, 12'd2048);
    chk("decay_attack14", level, 14);

    // Freeze across three windows, then resume in raw mode.
    freeze  = 1'b1;
    lv_snap = lv_cnt;
    window4(12'd4095, 12'd2048, 12'd2048, 12'd2048);
    window4(12'd2048, 12'd2048, 12'd2048, 12'd2048);
    window4(12'd3000, 12'd100, 12'd2048, 12'd2048);
    chk("freeze_level", level, 14);
    chk("freeze_bar", bar, 16'h7FFF);
    chk("freeze_no_valid", lv_cnt - lv_snap, 0);
    freeze   = 1'b0;
    decay_en = 1'b0;
    strobe(12'd2048);
    strobe(12'd3000);
    strobe(12'd2048);
    chk("unfreeze_aligned", lv_cnt - lv_snap, 0);
    strobe(12'd2048);
    chk("unfreeze_level", level, 7);
    chk("unfreeze_valid", level_valid, 1);

    // Inputs at or below the midpoint, and the first nonzero step.
    window4(12'd0, 12'd1000, 12'd2047, 12'd500);
    chk("below_mid_level", level, 0);
    chk("below_mid_bar", bar, 16'h0001);
    window4(12'd2048, 12'd2175, 12'd2176, 12'd0);
    chk("step1_level", level, 1);
    chk("step1_bar", bar, 16'h0003);

    // Back-to-back strobes into the 2-sample window.
    v2      = '{12'd2048, 12'd4095, 12'd2048, 12'd2176, 12'd3000, 12'd0};
    exp2    = '{15, 1, 7};
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        chk($sformatf("b2b_valid_%0d", k), level_valid2, ((k - 1) % 2 == 1) ? 1 : 0);
        if ((k - 1) % 2 == 1) begin
          chk($sformatf("b2b_level_%0d", k), level2, exp2[(k - 1) / 2]);
        end
      end
      if (k < 6) begin
        sample2       = v2[k];
        sample_valid2 = 1'b1;
      end else begin
        sample_valid2 = 1'b0;
      end
    end
    chk("b2b_bar", bar2, 16'h00FF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
